div_result_buffer: RTL

//  Downstream stage of the pipelined N-bit divider.
//  - Tracks which divider input slots carried valid operands.
//  - Captures the matching quotient/remainder LATENCY cycles later into an in-order FIFO.
//  - Presents results on a valid/ready interface; out_dbz flags divide-by-zero results.
//  - Issues credit (in_ready) so the non-stallable divider can never overrun the FIFO.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_result_buffer_if.sv | 60 ++++++
 rtl/div_tag_delay.sv | 48 ++++
 rtl/div_result_buffer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and default widths for the divider result buffer slice.
// Tags travel alongside the non-stallable divider pipeline; results are what
// the buffer stores and presents to the consumer.
package div_pkg;

   // Default operand widths: dividend/quotient and divisor/remainder.
   localparam int DIVIDEND_W = 3;
   localparam int DIVISOR_W  = 2;

   // One tag per divider issue slot: v marks a real operand pair,
   // dbz remembers that the divisor was zero.
   typedef struct packed {
      logic v;
      logic dbz;
   } tag_t;

   // One buffered result at the default widths.
   typedef struct packed {
      logic [DIVIDEND_W-1:0] quotient;
      logic [DIVISOR_W-1:0]  remainder;
      logic                  dbz;
   } result_t;

endpackage

// File: rtl/div_result_buffer_if.sv
// Bus bundle between the operand source / divider and the result consumer.
//
// Handshake rules (both sides):
//   in_valid/in_ready   : an operand pair is taken on a rising clock edge where
//                         both are high; in_valid while in_ready is low is a
//                         dropped slot (the divider cannot stall).
//   out_valid/out_ready : the head result is consumed on a rising clock edge
//                         where both are high; out_valid and out_* hold steady
//                         until that edge. in_ready never depends on out_ready
//                         within the same cycle.
interface div_result_buffer_if #(
   parameter int DIVIDEND = div_pkg::DIVIDEND_W,
   parameter int DIVISOR  = div_pkg::DIVISOR_W
);

   // Operand side
   logic                in_valid;
   logic [DIVISOR-1:0]  in_divisor;
   logic                in_ready;

   // Divider output side
   logic [DIVIDEND-1:0] div_quotient;
   logic [DIVISOR-1:0]  div_remainder;

   // Consumer side
   logic                out_valid;
   logic                out_ready;
   logic [DIVIDEND-1:0] out_quotient;
   logic [DIVISOR-1:0]  out_remainder;
   logic                out_dbz;

   // The buffer itself
   modport slave (
      input  in_valid,
      input  in_divisor,
      output in_ready,
      input  div_quotient,
      input  div_remainder,
      output out_valid,
      input  out_ready,
      output out_quotient,
      output out_remainder,
      output out_dbz
   );

   // The environment: operand source, divider and consumer
   modport master (
      output in_valid,
      output in_divisor,
      input  in_ready,
      output div_quotient,
      output div_remainder,
      input  out_valid,
      output out_ready,
      input  out_quotient,
      input  out_remainder,
      input  out_dbz
   );

endinterface

// File: rtl/div_tag_delay.sv
// LATENCY-deep shift line of tags that mirrors the divider pipeline, so the
// tag leaving the line lines up with the divider output for the same slot.
// Also keeps a registered count of valid tags currently in the line.
module div_tag_delay
   import div_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int CNT_W   = $clog2(LATENCY + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  tag_t             tag_in,
   output tag_t             tag_out,
   output logic [CNT_W-1:0] inflight
);

   tag_t line [LATENCY];

   // Shift tags one stage per clock; reset discards everything in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            line[i] <= '0;
         end
      end else begin
         line[0] <= tag_in;
         for (int i = 1; i < LATENCY; i++) begin
            line[i] <= line[i-1];
         end
      end
   end

   assign tag_out = line[LATENCY-1];

   // Track valid tags in the line: +1 on entry, -1 when one leaves.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= '0;
      end else begin
         case ({tag_in.v, tag_out.v})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= inflight - CNT_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: rtl/div_result_buffer.sv
// Result buffer behind a pipelined, non-stallable divider.
// Issue slots are tagged on entry, the tag line delays them by LATENCY, and
// matching divider outputs are captured into an in-order FIFO drained over
// a valid/ready port. Credit (in_ready) counts tags in flight plus FIFO
// entries, both registered, so a capture can never find the FIFO full.
//
// Build option: define DIV_ZERO_FIX_EN to store quotient=all ones and
// remainder=0 for divide-by-zero results; otherwise the raw divider outputs
// are stored. out_dbz is reported either way.
module div_result_buffer
   import div_pkg::*;
#(
   parameter int DIVIDEND = DIVIDEND_W,
   parameter int DIVISOR  = DIVISOR_W,
   parameter int LATENCY  = 3,
   parameter int DEPTH    = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   div_result_buffer_if.slave  bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int INF_W = $clog2(LATENCY + 1);
   localparam int SUM_W = $clog2(DEPTH + LATENCY + 1);

   // FIFO storage
   logic [DIVIDEND-1:0] q_mem   [DEPTH];
   logic [DIVISOR-1:0]  r_mem   [DEPTH];
   logic                dbz_mem [DEPTH];

   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [PTR_W-1:0]    head_nxt;
   logic [PTR_W-1:0]    tail_nxt;
   logic [CNT_W-1:0]    fifo_count;

   logic [INF_W-1:0]    inflight;
   logic [SUM_W-1:0]    outstanding;

   logic                in_ready;
   logic                out_valid;
   logic                accept;
   logic                capture;
   logic                pop;

   tag_t                tag_in;
   tag_t                tag_out;

   logic [DIVIDEND-1:0] cap_quotient;
   logic [DIVISOR-1:0]  cap_remainder;

   // Credit is computed from registered state only.
   assign outstanding = SUM_W'(fifo_count) + SUM_W'(inflight);
   assign in_ready    = (outstanding < SUM_W'(DEPTH));
   assign out_valid   = (fifo_count != '0);

   assign accept  = bus.in_valid & in_ready;
   assign pop     = out_valid & bus.out_ready;
   assign capture = tag_out.v;

   // Build the tag for this issue slot; dropped slots become empty tags.
   always_comb begin
      tag_in     = '0;
      tag_in.v   = accept;
      tag_in.dbz = accept & (bus.in_divisor == '0);
   end

   div_tag_delay #(
      .LATENCY (LATENCY),
      .CNT_W   (INF_W)
   ) u_tag_delay (
      .clock    (clock),
      .reset_n  (reset_n),
      .tag_in   (tag_in),
      .tag_out  (tag_out),
      .inflight (inflight)
   );

   // Select the data written on capture, optionally sanitising div-by-zero.
   always_comb begin
      cap_quotient  = bus.div_quotient;
      cap_remainder = bus.div_remainder;
`ifdef DIV_ZERO_FIX_EN
      if (tag_out.dbz) begin
         cap_quotient  = '1;
         cap_remainder = '0;
      end
`endif
   end

   // Pointer successors with explicit wrap at DEPTH (no power-of-two assumption).
   assign head_nxt = (head == PTR_W'(DEPTH - 1)) ? '0 : head + PTR_W'(1);
   assign tail_nxt = (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + PTR_W'(1);

   // Advance pointers and the occupancy count on capture and pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head       <= '0;
         tail       <= '0;
         fifo_count <= '0;
      end else begin
         if (capture) begin
            tail <= tail_nxt;
         end
         if (pop) begin
            head <= head_nxt;
         end
         case ({capture, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Write the captured result at the tail slot.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_mem[i]   <= '0;
            r_mem[i]   <= '0;
            dbz_mem[i] <= 1'b0;
         end
      end else if (capture) begin
         q_mem[tail]   <= cap_quotient;
         r_mem[tail]   <= cap_remainder;
         dbz_mem[tail] <= tag_out.dbz;
      end
   end

   // Present the head result; outputs read zero while the FIFO is empty.
   always_comb begin
      bus.out_quotient  = '0;
      bus.out_remainder = '0;
      bus.out_dbz       = 1'b0;
      if (out_valid) begin
         bus.out_quotient  = q_mem[head];
         bus.out_remainder = r_mem[head];
         bus.out_dbz       = dbz_mem[head];
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;

   // Credit accounting must keep every capture inside the FIFO.
   capture_fits: assert property (@(posedge clock) disable iff (!reset_n)
      capture |-> (fifo_count < CNT_W'(DEPTH)));

endmodule
